// File: rtl/lime_mem_unit.sv
// ---------------------------------------------------------------------------
// lime_mem_unit
//
// Memory/IR/MDR/PC slice of a small multicycle processor. A single op is
// accepted while idle, then runs a four-state FSM: IDLE -> REQ -> DONE, or
// IDLE -> DONE for the memory-mapped I/O address. The PC register updates
// every cycle, independently of the FSM, from new_pc under the branch rule.
//
// Optional feature (compile-time macro): LIME_MEM_TIMEOUT_EN
//   Adds a mem_ack watchdog. After TIMEOUT REQ cycles without an ack the op
//   leaves REQ through WAIT, finishes with done, and raises err. err stays set
//   until reset. Without the macro, REQ waits for an ack indefinitely and err
//   is tied low.
//
// Ports
//   CLK, reset        : clock and synchronous active-high reset
//   op_valid/op_ready : op handshake (op_ready high only in IDLE)
//   iord              : address select, 0 = pc, 1 = alu_out
//   op_we, ir_write   : write op / load IR when the read completes
//   alu_out, wr_data  : address source and write data
//   pc_write, new_pc, is_branch, branch_type, zero, negative : PC update
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack : memory port
//   processor_input/processor_output : memory-mapped I/O register pair
//   pc, ir, mdr       : architectural registers
//   done              : one-cycle completion pulse
//   err               : sticky watchdog error
// ---------------------------------------------------------------------------
module lime_mem_unit #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] IO_ADDR  = '1,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic              iord,
    input  logic              op_we,
    input  logic              ir_write,
    input  logic [DATA_W-1:0] alu_out,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pc_write,
    input  logic [DATA_W-1:0] new_pc,
    input  logic              is_branch,
    input  logic [1:0]        branch_type,
    input  logic              zero,
    input  logic              negative,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] processor_input,
    output logic [DATA_W-1:0] processor_output,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] mdr,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    if (ADDR_W > DATA_W || TIMEOUT == 0) begin : g_bad_params
        $error("lime_mem_unit: need ADDR_W <= DATA_W and TIMEOUT >= 1");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic              irw_q;
    logic [DATA_W-1:0] wdata_q;

    logic [ADDR_W-1:0] sel_addr;
    logic              io_hit;
    logic              accept;
    logic              taken;
    logic              timeout_hit;

    // Upper alu_out bits never take part in addressing.
    logic unused_alu_bits;
    assign unused_alu_bits = ^alu_out;

    assign sel_addr = iord ? alu_out[ADDR_W-1:0] : pc[ADDR_W-1:0];
    assign io_hit   = (sel_addr == IO_ADDR);

    // ------------------------------------------------------------------
    // Optional watchdog
    // ------------------------------------------------------------------
`ifdef LIME_MEM_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Counts un-acked REQ cycles; the last one (count TIMEOUT-1) trips it.
    assign timeout_hit = (state_q == REQ) && !mem_ack &&
                         (tmo_cnt == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge CLK) begin
        if (reset || state_q != REQ) begin
            tmo_cnt <= '0;
        end else if (!mem_ack) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (state_q == WAIT) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (op_valid) begin
                    accept  = 1'b1;
                    state_d = io_hit ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_d = DONE;
                end else if (timeout_hit) begin
                    state_d = WAIT;
                end
            end
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign op_ready  = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign mem_req   = (state_q == REQ);
    assign mem_we    = mem_req && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // ------------------------------------------------------------------
    // Latched op and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (reset) begin
            addr_q           <= '0;
            we_q             <= 1'b0;
            irw_q            <= 1'b0;
            wdata_q          <= '0;
            mdr              <= '0;
            ir               <= '0;
            processor_output <= '0;
        end else begin
            if (accept) begin
                addr_q  <= sel_addr;
                we_q    <= op_we;
                irw_q   <= ir_write;
                wdata_q <= wr_data;
                // I/O ops complete in the accept cycle itself.
                if (io_hit) begin
                    if (op_we) begin
                        processor_output <= wr_data;
                    end else begin
                        mdr <= processor_input;
                        if (ir_write) begin
                            ir <= processor_input;
                        end
                    end
                end
            end
            if (state_q == REQ && mem_ack && !we_q) begin
                mdr <= mem_rdata;
                if (irw_q) begin
                    ir <= mem_rdata;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // PC: independent of the FSM; the op address was already latched.
    // ------------------------------------------------------------------
    always_comb begin
        taken = 1'b0;
        unique case (branch_type)
            2'b00: taken = zero;
            2'b01: taken = !zero;
            2'b10: taken = negative;
            2'b11: taken = !negative;
            default: taken = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_write && (!is_branch || taken)) begin
            pc <= new_pc;
        end
    end

endmodule

// File: tb/tb_lime_mem_unit.sv
module tb_lime_mem_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid, op_ready, iord, op_we, ir_write;
    logic [15:0] alu_out, wr_data, new_pc;
    logic        pc_write, is_branch, zero, negative;
    logic [1:0]  branch_type;
    logic        mem_req, mem_we, mem_ack;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic [15:0] processor_input, processor_output, pc, ir, mdr;
    logic        done, err;

    always #5 clk = ~clk;

    lime_mem_unit #(
        .DATA_W (16),
        .ADDR_W (16),
        .TIMEOUT(4)
    ) dut (
        .CLK             (clk),
        .reset           (reset),
        .op_valid        (op_valid),
        .op_ready        (op_ready),
        .iord            (iord),
        .op_we           (op_we),
        .ir_write        (ir_write),
        .alu_out         (alu_out),
        .wr_data         (wr_data),
        .pc_write        (pc_write),
        .new_pc          (new_pc),
        .is_branch       (is_branch),
        .branch_type     (branch_type),
        .zero            (zero),
        .negative        (negative),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_ack         (mem_ack),
        .processor_input (processor_input),
        .processor_output(processor_output),
        .pc              (pc),
        .ir              (ir),
        .mdr             (mdr),
        .done            (done),
        .err             (err)
    );

    // Expected outcome of one op, checked when done pulses.
    typedef struct {
        int          lat;       // cycles from accept edge to done
        int          req;       // cycles with mem_req high
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
        logic [15:0] mdr;
        logic [15:0] ir;
        logic [15:0] pout;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    int          ack_delay = -1;   // -1: never ack
    logic [15:0] rdata_val = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory responder: acks after ack_delay un-acked REQ cycles.
    int wait_cnt = 0;
    always @(negedge clk) begin
        if (mem_req === 1'b1) begin
            if (wait_cnt == ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = rdata_val;
            end else begin
                mem_ack = 1'b0;
            end
            wait_cnt++;
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    // Monitor: measures each op and compares against the scoreboard head.
    bit          busy = 0;
    int          cyc = 0, req_cnt = 0;
    logic [15:0] seen_addr, seen_wdata;
    logic        seen_we;
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            busy = 0;
        end else begin
            if (busy) cyc++;
            if (mem_req === 1'b1) begin
                req_cnt++;
                seen_addr  = mem_addr;
                seen_we    = mem_we;
                seen_wdata = mem_wdata;
            end
            if (done === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("latency", cyc, e.lat);
                    check("req_cycles", req_cnt, e.req);
                    if (e.req > 0) begin
                        check("mem_addr", seen_addr, e.addr);
                        check("mem_we", seen_we, e.we);
                        check("mem_wdata", seen_wdata, e.wdata);
                    end
                    check("mdr", mdr, e.mdr);
                    check("ir", ir, e.ir);
                    check("processor_output", processor_output, e.pout);
                    check("err", err, e.err);
                end
                busy = 0;
            end
            if (op_valid === 1'b1 && op_ready === 1'b1) begin
                busy    = 1;
                cyc     = 0;
                req_cnt = 0;
            end
        end
    end

    task automatic do_op(input logic i_iord, input logic i_we, input logic i_irw,
                         input logic [15:0] i_alu, input logic [15:0] i_wd,
                         input logic [15:0] i_pin, input logic [15:0] i_rdata,
                         input int i_delay, input logic i_pcw, input logic [15:0] i_npc,
                         input exp_t e);
        processor_input = i_pin;
        rdata_val       = i_rdata;
        ack_delay       = i_delay;
        sb_q.push_back(e);
        op_valid  = 1'b1;
        iord      = i_iord;
        op_we     = i_we;
        ir_write  = i_irw;
        alu_out   = i_alu;
        wr_data   = i_wd;
        pc_write  = i_pcw;
        is_branch = 1'b0;
        new_pc    = i_npc;
        @(posedge clk); #1;
        op_valid = 1'b0;
        pc_write = 1'b0;
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(posedge clk);
        #1;
        if (sb_q.size() != 0) begin
            check("op_timeout", 32'd1, 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic pc_step(input logic br, input logic [1:0] bt, input logic z,
                           input logic n, input logic [15:0] npc);
        pc_write = 1'b1; is_branch = br; branch_type = bt;
        zero = z; negative = n; new_pc = npc;
        @(posedge clk); #1;
        pc_write = 1'b0; is_branch = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "bench timeout");
    end

    logic [15:0] br_exp_z[4] = '{16'h0010, 16'h0003, 16'h0003, 16'h0010};
    logic [15:0] br_exp_n[4] = '{16'h0003, 16'h0010, 16'h0010, 16'h0003};

    initial begin
        reset = 1'b1; op_valid = 0; iord = 0; op_we = 0; ir_write = 0;
        alu_out = 0; wr_data = 0; pc_write = 0; new_pc = 0; is_branch = 0;
        branch_type = 0; zero = 0; negative = 0; processor_input = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_ready", op_ready, 1'b1);
        check("rst_pc", pc, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_mdr", mdr, 16'h0000);
        check("rst_pout", processor_output, 16'h0000);
        check("rst_err", err, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        reset = 1'b0;
        @(posedge clk); #1;

        // Read at pc=0, immediate ack, load IR.
        do_op(0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 0, 0, 16'h0,
              '{lat:2, req:1, addr:16'h0000, we:0, wdata:16'h0000,
                mdr:16'hBEEF, ir:16'hBEEF, pout:16'h0000, err:0});
        // Write via alu_out, ack after 3 waits: mdr unchanged.
        do_op(1, 1, 0, 16'h0040, 16'h1234, 16'h0000, 16'hDEAD, 3, 0, 16'h0,
              '{lat:5, req:4, addr:16'h0040, we:1, wdata:16'h1234,
                mdr:16'hBEEF, ir:16'hBEEF, pout:16'h0000, err:0});
        // Read without IR load, one wait.
        do_op(1, 0, 0, 16'h0041, 16'h0000, 16'h0000, 16'h1111, 1, 0, 16'h0,
              '{lat:3, req:2, addr:16'h0041, we:0, wdata:16'h0000,
                mdr:16'h1111, ir:16'hBEEF, pout:16'h0000, err:0});
        // I/O write then I/O reads: no memory request.
        do_op(1, 1, 0, 16'hFFFF, 16'h00A5, 16'h0000, 16'h0000, 0, 0, 16'h0,
              '{lat:1, req:0, addr:16'h0, we:0, wdata:16'h0,
                mdr:16'h1111, ir:16'hBEEF, pout:16'h00A5, err:0});
        do_op(1, 0, 0, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h0000, 0, 0, 16'h0,
              '{lat:1, req:0, addr:16'h0, we:0, wdata:16'h0,
                mdr:16'h5A5A, ir:16'hBEEF, pout:16'h00A5, err:0});
        do_op(1, 0, 1, 16'hFFFF, 16'h0000, 16'h3C3C, 16'h0000, 0, 0, 16'h0,
              '{lat:1, req:0, addr:16'h0, we:0, wdata:16'h0,
                mdr:16'h3C3C, ir:16'h3C3C, pout:16'h00A5, err:0});

        // PC write in the accept cycle must not move the latched address.
        pc_step(0, 2'b00, 0, 0, 16'h0020);
        do_op(0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h2222, 2, 1, 16'h0099,
              '{lat:4, req:3, addr:16'h0020, we:0, wdata:16'h0000,
                mdr:16'h2222, ir:16'h2222, pout:16'h00A5, err:0});
        check("pc_after_op", pc, 16'h0099);

        // Branch conditions.
        for (int bt = 0; bt < 4; bt++) begin
            pc_step(0, 2'b00, 0, 0, 16'h0003);
            pc_step(1, 2'(bt), 1, 0, 16'h0010);
            check($sformatf("branch_z_bt%0d", bt), pc, br_exp_z[bt]);
            pc_step(0, 2'b00, 0, 0, 16'h0003);
            pc_step(1, 2'(bt), 0, 1, 16'h0010);
            check($sformatf("branch_n_bt%0d", bt), pc, br_exp_n[bt]);
        end

`ifdef LIME_MEM_TIMEOUT_EN
        // Never ack: 4 REQ cycles, WAIT, DONE with err; err sticky.
        do_op(1, 0, 1, 16'h0050, 16'h0000, 16'h0000, 16'h7777, -1, 0, 16'h0,
              '{lat:6, req:4, addr:16'h0050, we:0, wdata:16'h0000,
                mdr:16'h2222, ir:16'h2222, pout:16'h00A5, err:1});
        do_op(1, 1, 0, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 0, 0, 16'h0,
              '{lat:1, req:0, addr:16'h0, we:0, wdata:16'h0,
                mdr:16'h2222, ir:16'h2222, pout:16'h0001, err:1});
`else
        check("err_tied_low", err, 1'b0);
`endif

        // Reset during REQ aborts the op with no done pulse.
        ack_delay = -1;
        op_valid = 1'b1; iord = 1'b1; op_we = 1'b1; ir_write = 1'b0;
        alu_out = 16'h0060; wr_data = 16'h9999;
        @(posedge clk); #1;
        op_valid = 1'b0;
        check("abort_in_req", mem_req, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_op_ready", op_ready, 1'b1);
        check("abort_mem_req", mem_req, 1'b0);
        check("abort_pc", pc, 16'h0000);
        check("abort_done", done, 1'b0);
        check("abort_err", err, 1'b0);
        repeat (4) @(posedge clk);
        #1;

        // Reset wins over op_valid and pc_write in the same cycle.
        reset = 1'b1; op_valid = 1'b1; iord = 1'b1; alu_out = 16'h0070;
        pc_write = 1'b1; is_branch = 1'b0; new_pc = 16'h0077;
        @(posedge clk); #1;
        reset = 1'b0; op_valid = 1'b0; pc_write = 1'b0;
        check("prio_pc", pc, 16'h0000);
        check("prio_op_ready", op_ready, 1'b1);
        check("prio_mem_req", mem_req, 1'b0);
        repeat (3) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
